// File: rtl/axi4lite_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_arb_pkg
// Description : Shared state encodings and AXI response codes for the
//               two-master AXI4-Lite arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_arb_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] S_WR_REQ    = 3'd1;
    localparam logic [STATE_W-1:0] S_WR_WAIT_B = 3'd2;
    localparam logic [STATE_W-1:0] S_WR_RESP   = 3'd3;
    localparam logic [STATE_W-1:0] S_RD_REQ    = 3'd4;
    localparam logic [STATE_W-1:0] S_RD_WAIT_R = 3'd5;
    localparam logic [STATE_W-1:0] S_RD_RESP   = 3'd6;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/axi4lite_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_arb_rr
// Description : Two-way round-robin picker. On a tie the port that was not
//               granted last wins; the remembered port updates on advance.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic last_q;

    // Pick the single requester, or the non-last port on a tie
    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req[1];
        end
    end

    // Remember the most recent winner; starts at 1 so port 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_arb2.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_arb2
// Description : Two-master / one-slave AXI4-Lite arbiter with a single
//               transaction in flight. Requests are registered on accept,
//               replayed on the outport, and the captured response is
//               returned to the owning master only.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_arb2
    import axi4lite_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // inport 0 (CPU)
    input  logic              inport0_awvalid_i,
    input  logic [ADDR_W-1:0] inport0_awaddr_i,
    input  logic              inport0_wvalid_i,
    input  logic [31:0]       inport0_wdata_i,
    input  logic [3:0]        inport0_wstrb_i,
    input  logic              inport0_bready_i,
    input  logic              inport0_arvalid_i,
    input  logic [ADDR_W-1:0] inport0_araddr_i,
    input  logic              inport0_rready_i,
    output logic              inport0_awready_o,
    output logic              inport0_wready_o,
    output logic              inport0_arready_o,
    output logic              inport0_bvalid_o,
    output logic [1:0]        inport0_bresp_o,
    output logic              inport0_rvalid_o,
    output logic [31:0]       inport0_rdata_o,
    output logic [1:0]        inport0_rresp_o,
    // inport 1 (debug)
    input  logic              inport1_awvalid_i,
    input  logic [ADDR_W-1:0] inport1_awaddr_i,
    input  logic              inport1_wvalid_i,
    input  logic [31:0]       inport1_wdata_i,
    input  logic [3:0]        inport1_wstrb_i,
    input  logic              inport1_bready_i,
    input  logic              inport1_arvalid_i,
    input  logic [ADDR_W-1:0] inport1_araddr_i,
    input  logic              inport1_rready_i,
    output logic              inport1_awready_o,
    output logic              inport1_wready_o,
    output logic              inport1_arready_o,
    output logic              inport1_bvalid_o,
    output logic [1:0]        inport1_bresp_o,
    output logic              inport1_rvalid_o,
    output logic [31:0]       inport1_rdata_o,
    output logic [1:0]        inport1_rresp_o,
    // outport (to slave)
    output logic              outport_awvalid_o,
    output logic [ADDR_W-1:0] outport_awaddr_o,
    output logic              outport_wvalid_o,
    output logic [31:0]       outport_wdata_o,
    output logic [3:0]        outport_wstrb_o,
    output logic              outport_bready_o,
    output logic              outport_arvalid_o,
    output logic [ADDR_W-1:0] outport_araddr_o,
    output logic              outport_rready_o,
    input  logic              outport_awready_i,
    input  logic              outport_wready_i,
    input  logic              outport_bvalid_i,
    input  logic [1:0]        outport_bresp_i,
    input  logic              outport_arready_i,
    input  logic              outport_rvalid_i,
    input  logic [31:0]       outport_rdata_i,
    input  logic [1:0]        outport_rresp_i
);

    // Request decode: a write needs AW and W together; a lone AW is ignored
    logic [1:0] wr_req;
    logic [1:0] rd_req;
    logic [1:0] req;
    assign wr_req = {inport1_awvalid_i & inport1_wvalid_i, inport0_awvalid_i & inport0_wvalid_i};
    assign rd_req = {inport1_arvalid_i, inport0_arvalid_i};
    assign req    = wr_req | rd_req;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               grant_idx;
    logic               grant_valid;
    logic               gnt_q;
    logic               gnt_d;
    logic               accept;
    logic               accept_wr;

    // Accept only in IDLE and never while reset is asserted
    assign accept    = rst_i && (state_q == S_IDLE) && grant_valid;
    assign accept_wr = wr_req[grant_idx];

    axi4lite_arb_rr u_rr (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .req         (req),
        .advance     (accept),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Winner's request fields and the owner's response readies
    logic [ADDR_W-1:0] sel_awaddr;
    logic [ADDR_W-1:0] sel_araddr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_wstrb;
    logic              sel_bready;
    logic              sel_rready;
    assign sel_awaddr = grant_idx ? inport1_awaddr_i : inport0_awaddr_i;
    assign sel_araddr = grant_idx ? inport1_araddr_i : inport0_araddr_i;
    assign sel_wdata  = grant_idx ? inport1_wdata_i  : inport0_wdata_i;
    assign sel_wstrb  = grant_idx ? inport1_wstrb_i  : inport0_wstrb_i;
    assign sel_bready = gnt_q ? inport1_bready_i : inport0_bready_i;
    assign sel_rready = gnt_q ? inport1_rready_i : inport0_rready_i;

    // Registered outputs and their next values
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              bready_q, bready_d;
    logic              rready_q, rready_d;
    logic [1:0]        bvalid_q, bvalid_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q [2];
    logic [1:0]        rresp_q [2];
    logic [31:0]       rdata_q [2];

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; AW and W may finish in either order or together
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = accept_wr ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if ((!awvalid_q || outport_awready_i) && (!wvalid_q || outport_wready_i)) begin
                    state_d = S_WR_WAIT_B;
                end
            end
            S_WR_WAIT_B: if (outport_bvalid_i)  state_d = S_WR_RESP;
            S_WR_RESP:   if (sel_bready)        state_d = S_IDLE;
            S_RD_REQ:    if (outport_arready_i) state_d = S_RD_WAIT_R;
            S_RD_WAIT_R: if (outport_rvalid_i)  state_d = S_RD_RESP;
            S_RD_RESP:   if (sel_rready)        state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode: next value of every registered handshake output
    always_comb begin
        gnt_d     = accept ? grant_idx : gnt_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_q == S_IDLE) begin
            awvalid_d = accept && accept_wr;
            wvalid_d  = accept && accept_wr;
        end else if (state_q == S_WR_REQ) begin
            awvalid_d = awvalid_q && !outport_awready_i;
            wvalid_d  = wvalid_q && !outport_wready_i;
        end
        arvalid_d = (state_d == S_RD_REQ);
        bready_d  = (state_d == S_WR_WAIT_B);
        rready_d  = (state_d == S_RD_WAIT_R);
        bvalid_d  = {(state_d == S_WR_RESP) && gnt_d, (state_d == S_WR_RESP) && !gnt_d};
        rvalid_d  = {(state_d == S_RD_RESP) && gnt_d, (state_d == S_RD_RESP) && !gnt_d};
    end

    // Output, request capture and response capture registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            gnt_q      <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            bvalid_q   <= 2'b00;
            rvalid_q   <= 2'b00;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q[0] <= OKAY;
            bresp_q[1] <= OKAY;
            rresp_q[0] <= OKAY;
            rresp_q[1] <= OKAY;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            gnt_q     <= gnt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            if (accept) begin
                if (accept_wr) begin
                    awaddr_q <= sel_awaddr;
                    wdata_q  <= sel_wdata;
                    wstrb_q  <= sel_wstrb;
                end else begin
                    araddr_q <= sel_araddr;
                end
            end
            if ((state_q == S_WR_WAIT_B) && outport_bvalid_i) begin
                bresp_q[gnt_q] <= outport_bresp_i;
            end
            if ((state_q == S_RD_WAIT_R) && outport_rvalid_i) begin
                rdata_q[gnt_q] <= outport_rdata_i;
                rresp_q[gnt_q] <= outport_rresp_i;
            end
        end
    end

    // Accept readies are combinational and only reach the winner
    assign inport0_awready_o = accept && accept_wr && !grant_idx;
    assign inport0_wready_o  = accept && accept_wr && !grant_idx;
    assign inport0_arready_o = accept && !accept_wr && !grant_idx;
    assign inport1_awready_o = accept && accept_wr && grant_idx;
    assign inport1_wready_o  = accept && accept_wr && grant_idx;
    assign inport1_arready_o = accept && !accept_wr && grant_idx;

    assign inport0_bvalid_o = bvalid_q[0];
    assign inport0_bresp_o  = bresp_q[0];
    assign inport0_rvalid_o = rvalid_q[0];
    assign inport0_rdata_o  = rdata_q[0];
    assign inport0_rresp_o  = rresp_q[0];
    assign inport1_bvalid_o = bvalid_q[1];
    assign inport1_bresp_o  = bresp_q[1];
    assign inport1_rvalid_o = rvalid_q[1];
    assign inport1_rdata_o  = rdata_q[1];
    assign inport1_rresp_o  = rresp_q[1];

    assign outport_awvalid_o = awvalid_q;
    assign outport_awaddr_o  = awaddr_q;
    assign outport_wvalid_o  = wvalid_q;
    assign outport_wdata_o   = wdata_q;
    assign outport_wstrb_o   = wstrb_q;
    assign outport_bready_o  = bready_q;
    assign outport_arvalid_o = arvalid_q;
    assign outport_araddr_o  = araddr_q;
    assign outport_rready_o  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_arb2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_axi4lite_arb2
// Description : Directed, table-driven bench for the two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4lite_arb2;

    localparam int ADDR_W = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // master-side stimulus
    logic [1:0]        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [ADDR_W-1:0] m_awaddr [2];
    logic [ADDR_W-1:0] m_araddr [2];
    logic [31:0]       m_wdata  [2];
    logic [3:0]        m_wstrb  [2];
    // master-side DUT outputs
    wire [1:0]  m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    wire [1:0]  m_bresp [2];
    wire [1:0]  m_rresp [2];
    wire [31:0] m_rdata [2];
    // slave side
    wire              s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire [ADDR_W-1:0] s_awaddr, s_araddr;
    wire [31:0]       s_wdata;
    wire [3:0]        s_wstrb;
    logic             s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]       s_bresp, s_rresp;
    logic [31:0]      s_rdata;

    axi4lite_arb2 #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .inport0_awvalid_i(m_awvalid[0]), .inport0_awaddr_i(m_awaddr[0]),
        .inport0_wvalid_i(m_wvalid[0]), .inport0_wdata_i(m_wdata[0]), .inport0_wstrb_i(m_wstrb[0]),
        .inport0_bready_i(m_bready[0]), .inport0_arvalid_i(m_arvalid[0]), .inport0_araddr_i(m_araddr[0]),
        .inport0_rready_i(m_rready[0]),
        .inport0_awready_o(m_awready[0]), .inport0_wready_o(m_wready[0]), .inport0_arready_o(m_arready[0]),
        .inport0_bvalid_o(m_bvalid[0]), .inport0_bresp_o(m_bresp[0]),
        .inport0_rvalid_o(m_rvalid[0]), .inport0_rdata_o(m_rdata[0]), .inport0_rresp_o(m_rresp[0]),
        .inport1_awvalid_i(m_awvalid[1]), .inport1_awaddr_i(m_awaddr[1]),
        .inport1_wvalid_i(m_wvalid[1]), .inport1_wdata_i(m_wdata[1]), .inport1_wstrb_i(m_wstrb[1]),
        .inport1_bready_i(m_bready[1]), .inport1_arvalid_i(m_arvalid[1]), .inport1_araddr_i(m_araddr[1]),
        .inport1_rready_i(m_rready[1]),
        .inport1_awready_o(m_awready[1]), .inport1_wready_o(m_wready[1]), .inport1_arready_o(m_arready[1]),
        .inport1_bvalid_o(m_bvalid[1]), .inport1_bresp_o(m_bresp[1]),
        .inport1_rvalid_o(m_rvalid[1]), .inport1_rdata_o(m_rdata[1]), .inport1_rresp_o(m_rresp[1]),
        .outport_awvalid_o(s_awvalid), .outport_awaddr_o(s_awaddr),
        .outport_wvalid_o(s_wvalid), .outport_wdata_o(s_wdata), .outport_wstrb_o(s_wstrb),
        .outport_bready_o(s_bready), .outport_arvalid_o(s_arvalid), .outport_araddr_o(s_araddr),
        .outport_rready_o(s_rready),
        .outport_awready_i(s_awready), .outport_wready_i(s_wready),
        .outport_bvalid_i(s_bvalid), .outport_bresp_i(s_bresp),
        .outport_arready_i(s_arready), .outport_rvalid_i(s_rvalid),
        .outport_rdata_i(s_rdata), .outport_rresp_i(s_rresp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_arvalid = 2'b00;
        m_bready  = 2'b11; m_rready = 2'b11;
        s_awready = 1'b1;  s_wready = 1'b1;  s_arready = 1'b1;
        s_bvalid  = 1'b0;  s_rvalid = 1'b0;
        s_bresp   = OKAY;  s_rresp  = OKAY;  s_rdata  = 32'h0;
    endtask

    // kind: 0 none, 1 write, 2 read, 3 write+read, 4 AW without W
    task automatic set_req(input int n, input logic [2:0] k, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        m_awvalid[n] = (k == 3'd1) || (k == 3'd3) || (k == 3'd4);
        m_wvalid[n]  = (k == 3'd1) || (k == 3'd3);
        m_arvalid[n] = (k == 3'd2) || (k == 3'd3);
        m_awaddr[n]  = a;
        m_araddr[n]  = a;
        m_wdata[n]   = d;
        m_wstrb[n]   = s;
    endtask

    // zero-wait slave that answers whatever the DUT is waiting for
    task automatic drain(input int n);
        for (int c = 0; c < n; c++) begin
            s_bvalid = s_bready;
            s_rvalid = s_rready;
            tick();
        end
        s_bvalid = 1'b0;
        s_rvalid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_hs"}, {m_awready, m_wready, m_arready, m_bvalid, m_rvalid,
                           s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 32'h0);
        chk({tag, "_awaddr"}, s_awaddr, 32'h0);
        chk({tag, "_araddr"}, s_araddr, 32'h0);
        chk({tag, "_wdata"},  s_wdata, 32'h0);
        chk({tag, "_resp"},   {s_wstrb, m_bresp[0], m_bresp[1], m_rresp[0], m_rresp[1]}, 32'h0);
        chk({tag, "_rdata0"}, m_rdata[0], 32'h0);
        chk({tag, "_rdata1"}, m_rdata[1], 32'h0);
    endtask

    typedef struct {
        logic [2:0]  k0;
        logic [2:0]  k1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic        gnt;
        logic        wr;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int idx, input vec_t v);
        logic [1:0]  one;
        logic [31:0] addr;
        string       p;
        one  = v.gnt ? 2'b10 : 2'b01;
        addr = v.gnt ? v.a1 : v.a0;
        p    = $sformatf("v%0d", idx);
        idle_all();
        set_req(0, v.k0, v.a0, v.data, v.strb);
        set_req(1, v.k1, v.a1, v.data, v.strb);
        #1;
        chk({p, "_accept"}, {m_awready, m_wready, m_arready},
            v.wr ? {one, one, 2'b00} : {2'b00, 2'b00, one});
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_arvalid = 2'b00;
        if (v.wr) begin
            chk({p, "_wvalids"}, {s_awvalid, s_wvalid, s_arvalid}, 3'b110);
            chk({p, "_awaddr"}, s_awaddr, addr);
            chk({p, "_wdata"}, {s_wstrb, s_wdata[27:0]}, {v.strb, v.data[27:0]});
            tick();
            chk({p, "_bready"}, {s_awvalid, s_wvalid, s_bready}, 3'b001);
            s_bvalid = 1'b1; s_bresp = v.resp;
            tick();
            s_bvalid = 1'b0; s_bresp = ~v.resp;
            chk({p, "_bvalid"}, {m_bvalid, m_rvalid, s_bready}, {one, 2'b00, 1'b0});
            chk({p, "_bresp"}, m_bresp[v.gnt], v.resp);
            tick();
            chk({p, "_bdone"}, m_bvalid, 2'b00);
        end else begin
            chk({p, "_rvalids"}, {s_awvalid, s_wvalid, s_arvalid}, 3'b001);
            chk({p, "_araddr"}, s_araddr, addr);
            tick();
            chk({p, "_rready"}, {s_arvalid, s_rready}, 2'b01);
            s_rvalid = 1'b1; s_rdata = v.data; s_rresp = v.resp;
            tick();
            s_rvalid = 1'b0; s_rdata = ~v.data; s_rresp = ~v.resp;
            chk({p, "_rvalid"}, {m_rvalid, m_bvalid, s_rready}, {one, 2'b00, 1'b0});
            chk({p, "_rdata"}, m_rdata[v.gnt], v.data);
            chk({p, "_rresp"}, m_rresp[v.gnt], v.resp);
            tick();
            chk({p, "_rdone"}, m_rvalid, 2'b00);
        end
    endtask

    int grants [$];

    initial begin
        // k0, k1, a0, a1, data, strb, resp, gnt, wr ; last port starts at 1
        vecs[0] = '{3'd2, 3'd2, 32'h9000_0000, 32'h9000_0004, 32'h0000_1111, 4'hF, OKAY,   1'b0, 1'b0};
        vecs[1] = '{3'd1, 3'd0, 32'h9000_0008, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, OKAY,   1'b0, 1'b1};
        vecs[2] = '{3'd2, 3'd1, 32'h9000_0010, 32'h9000_0014, 32'h0BAD_F00D, 4'h5, SLVERR, 1'b1, 1'b1};
        vecs[3] = '{3'd0, 3'd2, 32'h0000_0000, 32'h9000_0018, 32'hCAFE_0003, 4'hF, OKAY,   1'b1, 1'b0};
        vecs[4] = '{3'd3, 3'd1, 32'h9000_0020, 32'h9000_0024, 32'h1234_0004, 4'h8, OKAY,   1'b0, 1'b1};
        vecs[5] = '{3'd4, 3'd2, 32'h9000_0028, 32'h9000_002C, 32'h5555_AAAA, 4'hF, SLVERR, 1'b1, 1'b0};
        vecs[6] = '{3'd1, 3'd0, 32'h9000_0030, 32'h0000_0000, 32'hFFFF_0000, 4'hC, OKAY,   1'b0, 1'b1};
        vecs[7] = '{3'd2, 3'd3, 32'h9000_0034, 32'h9000_0038, 32'h0F0F_0F0F, 4'hF, SLVERR, 1'b1, 1'b1};
        vecs[8] = '{3'd1, 3'd2, 32'h9000_003C, 32'h9000_0040, 32'h8765_4321, 4'h1, OKAY,   1'b0, 1'b1};

        for (int n = 0; n < 2; n++) set_req(n, 3'd0, 32'h0, 32'h0, 4'h0);
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Alternation: both ports hold a read request from reset
        idle_all();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_arvalid = 2'b11;
        for (int c = 0; c < 40 && grants.size() < 3; c++) begin
            s_rvalid = s_rready;
            s_rdata  = 32'(c);
            #1;
            if (m_arready[0]) grants.push_back(0);
            if (m_arready[1]) grants.push_back(1);
            tick();
        end
        m_arvalid = 2'b00;
        chk("alt_count", grants.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("alt_grant%0d", i), (i < grants.size()) ? grants[i] : 7, (i == 1) ? 1 : 0);
        end
        drain(6);

        // AW accepted 3 cycles late, W immediately
        idle_all();
        s_awready = 1'b0;
        set_req(0, 3'd1, 32'h9000_0044, 32'hA5A5_0001, 4'h3);
        #1;
        chk("dly_accept", {m_awready[0], m_wready[0]}, 2'b11);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("dly_hold%0d", c), {s_awvalid, s_wvalid, s_bready}, (c == 0) ? 3'b110 : 3'b100);
            tick();
        end
        s_awready = 1'b1;
        chk("dly_last", {s_awvalid, s_wvalid, s_bready}, 3'b100);
        tick();
        chk("dly_bready", {s_awvalid, s_wvalid, s_bready}, 3'b001);
        s_bvalid = 1'b1;
        tick();
        s_bvalid = 1'b0;
        chk("dly_bvalid", {m_bvalid, m_bresp[0]}, {2'b01, OKAY});
        tick();

        // SLVERR read on port 1 with the master stalling rready
        idle_all();
        m_rready[1] = 1'b0;
        set_req(1, 3'd2, 32'h9000_0100, 32'h0, 4'h0);
        #1;
        chk("stall_accept", m_arready, 2'b10);
        tick();
        m_arvalid = 2'b00;
        tick();
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rresp = SLVERR;
        tick();
        s_rvalid = 1'b0; s_rdata = 32'hFFFF_FFFF; s_rresp = OKAY;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall_hold%0d", c), {m_rvalid, m_rresp[1], m_rdata[1]},
                {2'b10, SLVERR, 32'h1234_5678});
            tick();
        end
        m_rready[1] = 1'b1;
        tick();
        chk("stall_done", m_rvalid, 2'b00);

        // Lone AW on port 0 does not block a port-1 read
        idle_all();
        set_req(0, 3'd4, 32'h9000_0200, 32'h7777_0000, 4'hF);
        set_req(1, 3'd2, 32'h9000_0204, 32'h0, 4'h0);
        #1;
        chk("awonly_accept", {m_awready, m_wready, m_arready}, 6'b000010);
        tick();
        m_arvalid = 2'b00;
        drain(3);
        chk("awonly_idle", {m_awready, m_wready, m_arready}, 6'b000000);
        tick();
        m_wvalid[0] = 1'b1;
        #1;
        chk("awonly_wrise", {m_awready, m_wready}, 4'b0101);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        drain(4);

        // Reset while waiting for B: abandon silently, tie goes to port 0
        idle_all();
        set_req(0, 3'd1, 32'h9000_0300, 32'h3333_3333, 4'hF);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        tick();
        chk("rstb_waitb", s_bready, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("rstb");
        s_bvalid = 1'b1; s_bresp = SLVERR;
        tick();
        s_bvalid = 1'b0;
        chk("rstb_nobvalid", {m_bvalid, s_bready}, 3'b000);
        set_req(0, 3'd1, 32'h9000_0304, 32'h4444_4444, 4'hF);
        set_req(1, 3'd2, 32'h9000_0308, 32'h0, 4'h0);
        #1;
        chk("rstb_tie", {m_awready, m_arready}, 4'b0100);
        tick();
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_arvalid = 2'b00;
        drain(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4lite_arb2.md
# axi4lite_arb2

Two-master, one-slave AXI4-Lite arbiter that shares the peripheral register bus (core_soc inport) between the CPU path (after axi4_axi4lite_conv) and a second master such as dbg_bridge. It allows exactly one transaction in flight at a time and grants the two ports round-robin. It registers each accepted request, replays it on the outport, and returns the captured response to the owning master.

## Interface
Parameters:
- ADDR_W, 32, address width of all AW/AR channels; data fixed at 32 bits, strobe at 4 bits.

Ports (N = 0, 1; inport0 = CPU, inport1 = debug):
- clk_i  in  1  single clock
- rst_i  in  1  reset, synchronous, active-low (asserted when 0)
- inportN_awvalid_i / awaddr_i  in  1 / ADDR_W  write address
- inportN_wvalid_i / wdata_i / wstrb_i  in  1 / 32 / 4  write data
- inportN_bready_i  in  1  write response ready
- inportN_arvalid_i / araddr_i  in  1 / ADDR_W  read address
- inportN_rready_i  in  1  read data ready
- inportN_awready_o / wready_o / arready_o  out  1  request accept
- inportN_bvalid_o / bresp_o  out  1 / 2  write response
- inportN_rvalid_o / rdata_o / rresp_o  out  1 / 32 / 2  read response
- outport_awvalid_o / awaddr_o, wvalid_o / wdata_o / wstrb_o, bready_o, arvalid_o / araddr_o, rready_o  out  master side to slave
- outport_awready_i, wready_i, bvalid_i / bresp_i, arready_i, rvalid_i / rdata_i / rresp_i  in  slave side

## Operation
- Port requests:
  - A write request is awvalid_i && wvalid_i on the same port. awvalid alone is not a request; that port waits and does not block the other port.
  - A read request is arvalid_i.
  - If a port raises both a write and a read request, the write wins.
- Arbitration happens only in IDLE.
  - If one port requests, it is granted.
  - If both request, the port other than last_q is granted, then last_q takes the granted index.
  - last_q resets to 1, so port 0 wins the first tie.
- States and transitions:
  - IDLE → WR_REQ or RD_REQ on grant. The address, data and strobe are registered, and the winner sees awready+wready (write) or arready (read) for exactly that cycle.
  - WR_REQ: drives outport awvalid and wvalid from the registers. Each valid drops independently on its ready. When both have been accepted → WR_WAIT_B.
  - WR_WAIT_B: bready_o=1. On bvalid_i, bresp is captured → WR_RESP.
  - WR_RESP: granted inportN_bvalid_o=1 holding the captured bresp. On bready_i → IDLE.
  - RD_REQ: arvalid_o=1 until arready_i → RD_WAIT_R.
  - RD_WAIT_R: rready_o=1. On rvalid_i, rdata and rresp are captured → RD_RESP.
  - RD_RESP: granted inportN_rvalid_o=1. On rready_i → IDLE.
- The non-granted port sees all readies and valids at 0. Its request is held by the master until a later IDLE.
- Responses route only to the granted port. The grant index is stable from accept until the response handshake completes.
- The slave's bresp and rresp are passed through unchanged. No error is generated locally.

## Timing
- Reset (rst_i=0 at a clock edge):
  - State → IDLE, last_q → 1.
  - Every valid and ready output → 0. Data, address and resp outputs → 0.
  - An in-flight transaction is abandoned silently, with no response to the master.
- Accept readies in IDLE are combinational from the inport valids. All outport and response outputs are registered.
- Write latency, with accept at T and zero-wait slave:
  - outport aw/w valid at T+1
  - slave bvalid earliest at T+2
  - inportN_bvalid at T+3
  - IDLE at T+4 if bready is already high
- Read latency: accept T → arvalid T+1 → rvalid_i earliest T+2 → inportN_rvalid T+3.
- Back-to-back throughput: one transaction per 4 cycles minimum.
- The outport only deasserts a valid after its handshake. AW and W may complete in either order or in the same cycle.

## Structure
- Package axi4lite_arb_pkg holds:
  - state encodings (IDLE, WR_REQ, WR_WAIT_B, WR_RESP, RD_REQ, RD_WAIT_R, RD_RESP)
  - the AXI resp constants OKAY=2'b00 and SLVERR=2'b10
- One natural sub-module: axi4lite_arb_rr, a 2-way round-robin picker holding last_q. Its inputs are req[1:0] and an advance strobe; its outputs are a grant index and a grant-valid flag.

## Test plan
- Port 0 writes 0xDEADBEEF, strobe 0xF, to 0x9000_0008 with zero-wait slave → outport awaddr 0x9000_0008 at T+1; inport0_bvalid at T+3 with bresp 0; port 1 sees no activity.
- Ports 0 and 1 read simultaneously from reset → port 0 served first; port 1 served next; third simultaneous pair goes to port 0 again (alternation).
- Slave delays awready by 3 cycles but accepts W immediately → wvalid drops after 1 cycle, awvalid held 3 cycles, bready asserted only after both accepted.
- Slave returns rresp=SLVERR, rdata=0x12345678 on port 1 read; master holds rready=0 for 5 cycles → rvalid, rdata and rresp stay stable for all 5 cycles and are delivered unchanged.
- Port 0 asserts awvalid without wvalid while port 1 reads → port 1 is granted; port 0 is not accepted until its wvalid rises.
- rst_i=0 for one cycle in WR_WAIT_B → all outputs 0 next cycle; state IDLE; no bvalid to any master; next tie goes to port 0.
